// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch over req/gnt, decode, exec, mem, writeback; optional CTRL_PERF_CNT_EN retire counter.
// Latency: BRANCH 3, STORE 4, OP/OP-IMM/JALR 4, LOAD 5 cycles with zero-wait grants; each extra wait cycle adds one.
// Backpressure: imem_req/dmem_req hold until their gnt; MAX_WAIT ungranted cycles raise sticky bus_err and park in TRAP.
module multicycle_ctrl #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   input  logic        imem_gnt,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir_q,
   input  logic        br_taken,
   output logic        alu_src_b,
   output logic [3:0]  alu_op,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_gnt,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        illegal,
   output logic        bus_err,
`ifdef CTRL_PERF_CNT_EN
   output logic [31:0] retire_cnt,
`endif
   output logic [2:0]  state_o
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

   state_t        state;
   logic [WW-1:0] wait_q;
   logic          run_q;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       is_load, is_opimm, is_store, is_branch, is_jalr, is_op;
   logic       legal;
   logic       waiting;
   logic       timeout;

   assign opcode = ir_q[6:0];
   assign funct3 = ir_q[14:12];
   assign funct7 = ir_q[31:25];

   assign is_load   = (opcode == OPC_LOAD);
   assign is_opimm  = (opcode == OPC_OPIMM);
   assign is_store  = (opcode == OPC_STORE);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_op     = (opcode == OPC_OP);

   // R-type accepts funct7 0000000 for all funct3, 0100000 only for SUB and SRA
   always_comb begin
      legal = is_load | is_opimm | is_store | is_branch | is_jalr | is_op;
      if (is_op) begin
         if (funct7 == 7'b0100000) begin
            legal = (funct3 == 3'b000) || (funct3 == 3'b101);
         end else if (funct7 != 7'b0000000) begin
            legal = 1'b0;
         end
      end
   end

   assign waiting = (imem_req && !imem_gnt) || (dmem_req && !dmem_gnt);
   assign timeout = (MAX_WAIT != 0) && waiting && (wait_q == WAIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         ir_q    <= 32'h0;
         wait_q  <= '0;
         illegal <= 1'b0;
         bus_err <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         run_q <= 1'b1;
         unique case (state)
            S_FETCH: begin
               if (imem_req) begin
                  if (imem_gnt) begin
                     ir_q  <= imem_rdata;
                     state <= S_DECODE;
                  end else if (timeout) begin
                     bus_err <= 1'b1;
                     state   <= S_TRAP;
                  end else begin
                     wait_q <= wait_q + 1'b1;
                  end
               end
            end
            S_DECODE: begin
               if (!legal) begin
                  illegal <= 1'b1;
                  state   <= S_TRAP;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_branch) begin
                  wait_q <= '0;
                  state  <= S_FETCH;
               end else if (is_load || is_store) begin
                  wait_q <= '0;
                  state  <= S_MEM;
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: begin
               if (dmem_gnt) begin
                  if (is_store) begin
                     wait_q <= '0;
                     state  <= S_FETCH;
                  end else begin
                     state <= S_WB;
                  end
               end else if (timeout) begin
                  bus_err <= 1'b1;
                  state   <= S_TRAP;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            S_WB: begin
               wait_q <= '0;
               state  <= S_FETCH;
            end
            S_TRAP: state <= S_TRAP;
            default: state <= S_TRAP;
         endcase
      end
   end

   // run_q keeps the fetch request low until the first edge after reset release
   assign imem_req = (state == S_FETCH) && run_q;
   assign dmem_req = (state == S_MEM);
   assign dmem_we  = (state == S_MEM) && is_store;
   assign rf_we    = (state == S_WB);
   assign state_o  = state;

   always_comb begin
      wb_sel = 2'b00;
      if (state == S_WB) begin
         if (is_jalr) begin
            wb_sel = 2'b10;
         end else if (is_load) begin
            wb_sel = 2'b01;
         end
      end
   end

   always_comb begin
      pc_we  = 1'b0;
      pc_sel = 2'b00;
      unique case (state)
         S_EXEC: begin
            if (is_branch) begin
               pc_we  = 1'b1;
               pc_sel = {1'b0, br_taken};
            end
         end
         S_MEM: pc_we = is_store && dmem_gnt;
         S_WB: begin
            pc_we  = 1'b1;
            pc_sel = is_jalr ? 2'b10 : 2'b00;
         end
         default: begin
            pc_we  = 1'b0;
            pc_sel = 2'b00;
         end
      endcase
   end

   // shift-immediates carry the arithmetic/logical select in funct7[5] just like R-type
   always_comb begin
      alu_src_b = !(is_op || is_branch);
      alu_op    = 4'b0000;
      if (is_branch) begin
         alu_op = 4'b1000;
      end else if (is_op || (is_opimm && funct3 == 3'b101)) begin
         alu_op = {funct7[5], funct3};
      end else if (is_opimm) begin
         alu_op = {1'b0, funct3};
      end
   end

`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_cnt <= 32'h0;
      end else if (pc_we) begin
         retire_cnt <= retire_cnt + 32'd1;
      end
   end
`endif

endmodule
